// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access pipeline stage.
package mem_stage_pkg;

   localparam int unsigned RF_AW = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned FWD_W = 38;

   // Bit positions inside the exe_mem_all field
   localparam int unsigned MEM_WE = 7;
   localparam int unsigned LD_B   = 6;
   localparam int unsigned LD_H   = 5;
   localparam int unsigned LD_W   = 4;
   localparam int unsigned LD_UE  = 3;
   localparam int unsigned ST_B   = 2;
   localparam int unsigned ST_H   = 1;
   localparam int unsigned ST_W   = 0;

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of the SRAM read word and extends it.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [DW-1:0] rdata,
   input  logic [1:0]    addr_lo,
   input  logic          ld_b,
   input  logic          ld_h,
   input  logic          ld_ue,
   output logic [DW-1:0] result_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      // Word loads pass through untouched
      result_c = rdata;
      if (ld_b)
         result_c = {{24{~ld_ue & byte_sel[7]}}, byte_sel};
      else if (ld_h)
         result_c = {{16{~ld_ue & half_sel[15]}}, half_sel};
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues the SRAM request on transfer, then
// aligns the returned read data, holding it in a buffer across wb stalls.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              exe_to_mem_valid,
   output logic              mem_allowin,
   input  logic [DW-1:0]     exe_pc,
   input  logic [DW-1:0]     exe_result,
   input  logic              exe_rf_we,
   input  logic [RF_AW-1:0]  exe_rf_waddr,
   input  logic              exe_res_from_mem,
   input  logic [7:0]        exe_mem_all,
   input  logic [DW-1:0]     exe_rkd_value,
   output logic              data_sram_en,
   output logic [3:0]        data_sram_we,
   output logic [DW-1:0]     data_sram_addr,
   output logic [DW-1:0]     data_sram_wdata,
   input  logic [DW-1:0]     data_sram_rdata,
   input  logic              wb_allowin,
   output logic              mem_to_wb_valid,
   output logic [DW-1:0]     mem_pc,
   output logic              mem_rf_we,
   output logic [RF_AW-1:0]  mem_rf_waddr,
   output logic [DW-1:0]     mem_final_result,
   output logic [FWD_W-1:0]  mem_fwd_all
);

   logic             mem_valid;
   logic             first_cyc;
   logic             buf_vld;
   logic [DW-1:0]    rdata_buf;
   logic [DW-1:0]    pc_q;
   logic [DW-1:0]    result_q;
   logic             rf_we_q;
   logic [RF_AW-1:0] waddr_q;
   logic             load_q;
   logic             ld_b_q;
   logic             ld_h_q;
   logic             ld_ue_q;
   logic [1:0]       addr_lo_q;

   logic             transfer;
   logic             is_load;
   logic             capture;
   logic [DW-1:0]    eff_rdata;
   logic [DW-1:0]    load_data;

   assign mem_allowin = ~mem_valid | wb_allowin;
   assign transfer    = exe_to_mem_valid & mem_allowin;
   assign is_load     = exe_res_from_mem | exe_mem_all[LD_B] | exe_mem_all[LD_H]
                      | exe_mem_all[LD_W];
   // Read data is only live in the first cycle; save it if wb is stalling us
   assign capture     = first_cyc & load_q & ~wb_allowin;

   // SRAM request, issued in the transfer cycle
   assign data_sram_en   = transfer & (is_load | exe_mem_all[MEM_WE]);
   assign data_sram_addr = exe_result;

   always_comb begin
      data_sram_we    = 4'b0000;
      data_sram_wdata = exe_rkd_value;
      if (exe_mem_all[ST_B])
         data_sram_wdata = {4{exe_rkd_value[7:0]}};
      else if (exe_mem_all[ST_H])
         data_sram_wdata = {2{exe_rkd_value[15:0]}};
      if (transfer & exe_mem_all[MEM_WE]) begin
         if (exe_mem_all[ST_B])
            data_sram_we = 4'b0001 << exe_result[1:0];
         else if (exe_mem_all[ST_H])
            data_sram_we = exe_result[1] ? 4'b1100 : 4'b0011;
         else if (exe_mem_all[ST_W])
            data_sram_we = 4'b1111;
      end
   end

   // Control state
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid <= 1'b0;
         first_cyc <= 1'b0;
         buf_vld   <= 1'b0;
         rf_we_q   <= 1'b0;
      end else begin
         if (mem_allowin)
            mem_valid <= exe_to_mem_valid;
         first_cyc <= transfer;
         if (transfer)
            rf_we_q <= exe_rf_we;
         if (mem_valid & wb_allowin)
            buf_vld <= 1'b0;
         else if (capture)
            buf_vld <= 1'b1;
      end
   end

   // Payload registers need no reset
   always_ff @(posedge clk) begin
      if (transfer) begin
         pc_q      <= exe_pc;
         result_q  <= exe_result;
         waddr_q   <= exe_rf_waddr;
         load_q    <= exe_res_from_mem;
         ld_b_q    <= exe_mem_all[LD_B];
         ld_h_q    <= exe_mem_all[LD_H];
         ld_ue_q   <= exe_mem_all[LD_UE];
         addr_lo_q <= exe_result[1:0];
      end
      if (capture)
         rdata_buf <= data_sram_rdata;
   end

   assign eff_rdata = buf_vld ? rdata_buf : data_sram_rdata;

   mem_load_align u_align (
      .rdata    (eff_rdata),
      .addr_lo  (addr_lo_q),
      .ld_b     (ld_b_q),
      .ld_h     (ld_h_q),
      .ld_ue    (ld_ue_q),
      .result_c (load_data)
   );

   assign mem_to_wb_valid  = mem_valid;
   assign mem_pc           = pc_q;
   assign mem_rf_we        = rf_we_q;
   assign mem_rf_waddr     = waddr_q;
   assign mem_final_result = load_q ? load_data : result_q;
   assign mem_fwd_all      = {mem_valid & rf_we_q, waddr_q, mem_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, stall/reset sequences,
// and randomized traffic against a behavioural model.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        exe_to_mem_valid;
   logic        mem_allowin;
   logic [31:0] exe_pc;
   logic [31:0] exe_result;
   logic        exe_rf_we;
   logic [4:0]  exe_rf_waddr;
   logic        exe_res_from_mem;
   logic [7:0]  exe_mem_all;
   logic [31:0] exe_rkd_value;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        wb_allowin;
   logic        mem_to_wb_valid;
   logic [31:0] mem_pc;
   logic        mem_rf_we;
   logic [4:0]  mem_rf_waddr;
   logic [31:0] mem_final_result;
   logic [37:0] mem_fwd_all;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk              (clk),
      .reset            (reset),
      .exe_to_mem_valid (exe_to_mem_valid),
      .mem_allowin      (mem_allowin),
      .exe_pc           (exe_pc),
      .exe_result       (exe_result),
      .exe_rf_we        (exe_rf_we),
      .exe_rf_waddr     (exe_rf_waddr),
      .exe_res_from_mem (exe_res_from_mem),
      .exe_mem_all      (exe_mem_all),
      .exe_rkd_value    (exe_rkd_value),
      .data_sram_en     (data_sram_en),
      .data_sram_we     (data_sram_we),
      .data_sram_addr   (data_sram_addr),
      .data_sram_wdata  (data_sram_wdata),
      .data_sram_rdata  (data_sram_rdata),
      .wb_allowin       (wb_allowin),
      .mem_to_wb_valid  (mem_to_wb_valid),
      .mem_pc           (mem_pc),
      .mem_rf_we        (mem_rf_we),
      .mem_rf_waddr     (mem_rf_waddr),
      .mem_final_result (mem_final_result),
      .mem_fwd_all      (mem_fwd_all)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] rkd;
      logic [31:0] rdata;
      logic        en;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] res;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic v, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] rkd, input logic [31:0] pc, input logic [4:0] wa);
      exe_to_mem_valid = v;
      exe_mem_all      = op;
      exe_res_from_mem = op[6] | op[5] | op[4];
      exe_rf_we        = ~op[7];
      exe_result       = addr;
      exe_rkd_value    = rkd;
      exe_pc           = pc;
      exe_rf_waddr     = wa;
   endtask

   // Load result from the rules: shift the addressed lane down, mask, extend
   function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
      logic [31:0] v;
      int unsigned a;
      a = int'(addr[1:0]);
      if (op[6]) begin
         v = (rdata >> (8 * a)) & 32'h0000_00FF;
         if (!op[3] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (op[5]) begin
         v = (rdata >> (16 * (a / 2))) & 32'h0000_FFFF;
         if (!op[3] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_we(input logic [7:0] op, input logic [31:0] addr);
      int unsigned a;
      a = int'(addr[1:0]);
      if (!op[7]) return 4'b0000;
      if (op[2]) return 4'(1 << a);
      if (op[1]) return (a >= 2) ? 4'b1100 : 4'b0011;
      if (op[0]) return 4'b1111;
      return 4'b0000;
   endfunction

   // Expected content of each written byte lane
   function automatic logic [31:0] ref_lanes(input logic [7:0] op, input logic [31:0] rkd,
                                             input logic [3:0] we);
      logic [31:0] w;
      w = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            if (op[2])      w[8*i +: 8] = rkd[7:0];
            else if (op[1]) w[8*i +: 8] = rkd[8*(i%2) +: 8];
            else            w[8*i +: 8] = rkd[8*i +: 8];
         end
      end
      return w;
   endfunction

   function automatic logic [31:0] mask_we(input logic [31:0] d, input logic [3:0] we);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = we[i] ? d[8*i +: 8] : 8'h00;
      return w;
   endfunction

   // Behavioural model state for the random phase
   logic        m_valid, m_first, m_rfwe, m_load;
   logic [7:0]  m_op;
   logic [31:0] m_addr, m_pc, m_data, m_exp;
   logic [4:0]  m_waddr;

   logic [7:0] ops[9];
   logic [7:0] r_op;
   logic [31:0] r_addr, r_rkd;
   logic        r_v, exp_allow, xfer;
   logic [3:0]  exp_we;

   initial begin
      vecs[0] = '{8'h40, 32'h0000_1003, 32'h0,         32'h8012_3456, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80};
      vecs[1] = '{8'h48, 32'h0000_1003, 32'h0,         32'h8012_3456, 1'b1, 4'b0000, 32'h0,         32'h0000_0080};
      vecs[2] = '{8'h28, 32'h0000_2002, 32'h0,         32'h8001_1234, 1'b1, 4'b0000, 32'h0,         32'h0000_8001};
      vecs[3] = '{8'h20, 32'h0000_2000, 32'h0,         32'h8001_1234, 1'b1, 4'b0000, 32'h0,         32'h0000_1234};
      vecs[4] = '{8'h84, 32'h0000_1001, 32'h0000_00AB, 32'h0,         1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0000_1001};
      vecs[5] = '{8'h82, 32'h0000_1002, 32'h1234_CDEF, 32'h0,         1'b1, 4'b1100, 32'hCDEF_CDEF, 32'h0000_1002};
      vecs[6] = '{8'h10, 32'h0000_3004, 32'h0,         32'hCAFE_F00D, 1'b1, 4'b0000, 32'h0,         32'hCAFE_F00D};
      vecs[7] = '{8'h00, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0,         32'h1234_5678};
      vecs[8] = '{8'h81, 32'h0000_0040, 32'h1122_3344, 32'h0,         1'b1, 4'b1111, 32'h1122_3344, 32'h0000_0040};
      vecs[9] = '{8'h40, 32'h0000_0005, 32'h0,         32'h0000_7F00, 1'b1, 4'b0000, 32'h0,         32'h0000_007F};
      ops = '{8'h00, 8'h40, 8'h48, 8'h20, 8'h28, 8'h10, 8'h84, 8'h82, 8'h81};

      reset = 1'b1;
      wb_allowin = 1'b1;
      data_sram_rdata = 32'h0;
      drive_op(1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0);
      step();
      step();
      @(negedge clk);
      chk("reset_valid", 64'(mem_to_wb_valid), 64'd0);
      chk("reset_fwd_we", 64'(mem_fwd_all[37]), 64'd0);
      chk("reset_rf_we", 64'(mem_rf_we), 64'd0);
      chk("reset_allowin", 64'(mem_allowin), 64'd1);
      step();
      reset = 1'b0;

      // Directed single-instruction vectors
      for (int i = 0; i < 10; i++) begin
         drive_op(1'b1, vecs[i].op, vecs[i].addr, vecs[i].rkd, 32'h1000_0000 + 32'(i * 4), 5'(i + 1));
         data_sram_rdata = 32'h5555_5555;
         @(negedge clk);
         chk($sformatf("v%0d_en", i), 64'(data_sram_en), 64'(vecs[i].en));
         chk($sformatf("v%0d_we", i), 64'(data_sram_we), 64'(vecs[i].we));
         chk($sformatf("v%0d_addr", i), 64'(data_sram_addr), 64'(vecs[i].addr));
         if (vecs[i].we != 4'b0000)
            chk($sformatf("v%0d_wdata", i), 64'(data_sram_wdata), 64'(vecs[i].wdata));
         step();
         exe_to_mem_valid = 1'b0;
         data_sram_rdata  = vecs[i].rdata;
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 64'(mem_to_wb_valid), 64'd1);
         chk($sformatf("v%0d_result", i), 64'(mem_final_result), 64'(vecs[i].res));
         chk($sformatf("v%0d_pc", i), 64'(mem_pc), 64'(32'h1000_0000 + 32'(i * 4)));
         chk($sformatf("v%0d_fwd", i), 64'(mem_fwd_all),
             64'({~vecs[i].op[7], 5'(i + 1), vecs[i].res}));
         chk($sformatf("v%0d_no_req", i), 64'(data_sram_en), 64'd0);
         step();
      end

      // Load stalled in the stage for 3 cycles while rdata goes away
      drive_op(1'b1, 8'h10, 32'h0000_4000, 32'h0, 32'h2000_0000, 5'd7);
      wb_allowin = 1'b0;
      @(negedge clk);
      chk("stall_req_en", 64'(data_sram_en), 64'd1);
      step();
      drive_op(1'b1, 8'h00, 32'h0000_0777, 32'h0, 32'h2000_0004, 5'd8);
      data_sram_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_result", c), 64'(mem_final_result), 64'h0000_0000_DEAD_BEEF);
         chk($sformatf("stall%0d_allowin", c), 64'(mem_allowin), 64'd0);
         chk($sformatf("stall%0d_en", c), 64'(data_sram_en), 64'd0);
         step();
         data_sram_rdata = 32'h0;
      end
      wb_allowin = 1'b1;
      @(negedge clk);
      chk("release_result", 64'(mem_final_result), 64'h0000_0000_DEAD_BEEF);
      chk("release_valid", 64'(mem_to_wb_valid), 64'd1);
      chk("release_allowin", 64'(mem_allowin), 64'd1);
      step();
      exe_to_mem_valid = 1'b0;
      @(negedge clk);
      chk("follow_result", 64'(mem_final_result), 64'h777);
      chk("follow_pc", 64'(mem_pc), 64'h2000_0004);
      step();

      // Reset in the middle of a stall
      drive_op(1'b1, 8'h10, 32'h0000_4000, 32'h0, 32'h3000_0000, 5'd9);
      wb_allowin = 1'b0;
      step();
      exe_to_mem_valid = 1'b0;
      data_sram_rdata = 32'hDEAD_BEEF;
      step();
      reset = 1'b1;
      data_sram_rdata = 32'h0;
      step();
      @(negedge clk);
      chk("rst_stall_valid", 64'(mem_to_wb_valid), 64'd0);
      chk("rst_stall_fwd_we", 64'(mem_fwd_all[37]), 64'd0);
      step();
      reset = 1'b0;
      wb_allowin = 1'b1;
      drive_op(1'b1, 8'h10, 32'h0000_4000, 32'h0, 32'h3000_0010, 5'd10);
      step();
      exe_to_mem_valid = 1'b0;
      data_sram_rdata = 32'h1357_9BDF;
      @(negedge clk);
      chk("post_rst_fresh_rdata", 64'(mem_final_result), 64'h1357_9BDF);
      step();

      // Back-to-back ALU ops stream one per cycle with no SRAM traffic
      for (int k = 0; k < 5; k++) begin
         drive_op(k < 4, 8'h00, 32'hA000_0000 + 32'(k), 32'h0, 32'h4000_0000 + 32'(k * 4), 5'(k + 3));
         @(negedge clk);
         if (k < 4) chk($sformatf("alu%0d_en", k), 64'(data_sram_en), 64'd0);
         if (k > 0) begin
            chk($sformatf("alu%0d_valid", k), 64'(mem_to_wb_valid), 64'd1);
            chk($sformatf("alu%0d_result", k), 64'(mem_final_result), 64'(32'hA000_0000 + 32'(k - 1)));
         end
         step();
      end
      exe_to_mem_valid = 1'b0;
      step();
      step();

      // Random traffic against the behavioural model (stage is empty here)
      m_valid = 1'b0;
      m_first = 1'b0;
      for (int n = 0; n < 400; n++) begin
         r_v   = 1'($urandom_range(0, 3) != 0);
         r_op  = ops[$urandom_range(0, 8)];
         r_addr = $urandom;
         r_rkd = $urandom;
         drive_op(r_v, r_op, r_addr, r_rkd, $urandom, 5'($urandom));
         wb_allowin = 1'($urandom_range(0, 2) != 0);
         data_sram_rdata = $urandom;
         @(negedge clk);
         exp_allow = ~m_valid | wb_allowin;
         chk("rnd_allowin", 64'(mem_allowin), 64'(exp_allow));
         if (m_valid) begin
            if (m_first) m_data = data_sram_rdata;
            m_first = 1'b0;
            m_exp = m_load ? ref_load(m_op, m_addr, m_data) : m_addr;
            chk("rnd_valid", 64'(mem_to_wb_valid), 64'd1);
            chk("rnd_result", 64'(mem_final_result), 64'(m_exp));
            chk("rnd_pc", 64'(mem_pc), 64'(m_pc));
            chk("rnd_fwd", 64'(mem_fwd_all), 64'({m_rfwe, m_waddr, m_exp}));
            if (wb_allowin) m_valid = 1'b0;
         end else begin
            chk("rnd_idle", 64'(mem_to_wb_valid), 64'd0);
         end
         xfer = r_v & exp_allow;
         chk("rnd_en", 64'(data_sram_en), 64'(xfer & (r_op[7] | r_op[6] | r_op[5] | r_op[4])));
         exp_we = xfer ? ref_we(r_op, r_addr) : 4'b0000;
         chk("rnd_we", 64'(data_sram_we), 64'(exp_we));
         if (exp_we != 4'b0000)
            chk("rnd_wdata", 64'(mask_we(data_sram_wdata, exp_we)), 64'(ref_lanes(r_op, r_rkd, exp_we)));
         if (xfer) begin
            m_valid = 1'b1;
            m_first = 1'b1;
            m_op    = r_op;
            m_addr  = r_addr;
            m_pc    = exe_pc;
            m_waddr = exe_rf_waddr;
            m_rfwe  = ~r_op[7];
            m_load  = r_op[6] | r_op[5] | r_op[4];
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
